// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg -- shared definitions for the iterative multiply/divide unit.
//   op_e     : operation encoding as presented on the op port
//   state_e  : controller FSM state encoding
//   ITER_CNT : number of radix-2 steps per operation
// Optional build macro used by the unit: MULDIV_FAST_MULT_EN.
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam int ITER_CNT = 32;
    localparam int CNT_W    = $clog2(ITER_CNT);

    function automatic logic is_div_op(input op_e op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(input op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step -- one combinational radix-2 step on a 64-bit working register.
//   is_div   : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_in   : multiply {partial product, remaining multiplier bits}
//              divide   {partial remainder, dividend/quotient bits}
//   operand  : multiplicand or divisor magnitude
//   acc_out  : working register after this step
// -----------------------------------------------------------------------------
module muldiv_step (
    input  logic        is_div,
    input  logic [63:0] acc_in,
    input  logic [31:0] operand,
    output logic [63:0] acc_out
);

    logic [32:0] sum;
    logic [32:0] diff;

    always_comb begin
        // Multiply: add the multiplicand when the current multiplier LSB is
        // set, then shift right; the carry becomes the new top bit.
        sum  = {1'b0, acc_in[63:32]} + (acc_in[0] ? {1'b0, operand} : 33'd0);
        // Divide: trial-subtract the divisor from the left-shifted remainder.
        // The shifted remainder is below 2*divisor, so bit 32 is a clean borrow.
        diff = acc_in[63:31] - {1'b0, operand};

        if (is_div) begin
            if (!diff[32]) begin
                acc_out = {diff[31:0], acc_in[30:0], 1'b1};
            end else begin
                acc_out = {acc_in[62:0], 1'b0};
            end
        end else begin
            acc_out = {sum, acc_in[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl -- HI/LO multiply/divide unit with iterative datapath.
//   clk, rst_n        : clock, synchronous active-low reset
//   start, op         : launch request and operation (MULT/MULTU/DIV/DIVU)
//   data1, data2      : multiplicand/dividend, multiplier/divisor
//   flush             : abort the in-flight operation, HI/LO untouched
//   hi_we, lo_we      : MTHI/MTLO strobes with shared wdata, honoured when idle
//   busy, done        : operation in flight / one-cycle completion pulse
//   hi, lo            : architectural HI/LO registers
// Build macro MULDIV_FAST_MULT_EN: MULT/MULTU use a single-cycle multiplier
// and skip CALC; division stays iterative.
// -----------------------------------------------------------------------------
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt;

    op_e              op_in;
    logic             accept;
    logic             fast_op;
    logic             op_signed, sign1, sign2;
    logic [31:0]      mag1, mag2;

    op_e              op_q;
    logic [31:0]      data1_q;
    logic [31:0]      operand_q;
    logic [63:0]      acc_q;
    logic [63:0]      step_acc;
    logic             neg_q, neg_r, div_zero_q;
    logic             op_q_div;
    logic [31:0]      res_hi, res_lo;

    assign op_in    = op_e'(op);
    assign op_q_div = is_div_op(op_q);
    assign accept   = (state == ST_IDLE || state == ST_DONE) && start && !flush;

    // Operand signs and magnitudes; unsigned ops never see a sign.
    always_comb begin
        op_signed = is_signed_op(op_in);
        sign1     = op_signed & data1[31];
        sign2     = op_signed & data2[31];
        mag1      = sign1 ? -data1 : data1;
        mag2      = sign2 ? -data2 : data2;
    end

`ifdef MULDIV_FAST_MULT_EN
    logic signed [32:0] fast_a, fast_b;
    logic        [63:0] fast_prod;

    // 33x33 signed multiply: the extra bit carries sign for MULT and zero for
    // MULTU, so one multiplier serves both; only the low 64 bits matter.
    assign fast_a    = {sign1, data1};
    assign fast_b    = {sign2, data2};
    assign fast_prod = 64'(64'(fast_a) * 64'(fast_b));
    assign fast_op   = !is_div_op(op_in);
`else
    assign fast_op   = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: the default at the top keeps every path assigned, so no latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) state_nxt = fast_op ? ST_FIX : ST_CALC;
                else        state_nxt = ST_IDLE;
            end
            ST_CALC: begin
                if (flush)                             state_nxt = ST_IDLE;
                else if (cnt == CNT_W'(ITER_CNT - 1))  state_nxt = ST_FIX;
            end
            ST_FIX: begin
                state_nxt = flush ? ST_IDLE : ST_DONE;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state == ST_CALC) || (state == ST_FIX);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                cnt <= '0;
        else if (accept)           cnt <= '0;
        else if (state == ST_CALC) cnt <= cnt + CNT_W'(1);
    end

    // ---------------- datapath ----------------
    muldiv_step u_step (
        .is_div  (op_q_div),
        .acc_in  (acc_q),
        .operand (operand_q),
        .acc_out (step_acc)
    );

    // NOTE: datapath registers carry no reset; each is loaded on accept before
    // the FSM can consume it, so reset only needs to cover control and HI/LO.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q       <= op_in;
            data1_q    <= data1;
            div_zero_q <= (data2 == 32'd0);
            neg_q      <= sign1 ^ sign2;
            neg_r      <= sign1;
            if (is_div_op(op_in)) begin
                acc_q     <= {32'd0, mag1};
                operand_q <= mag2;
            end else begin
                acc_q     <= {32'd0, mag2};
                operand_q <= mag1;
            end
`ifdef MULDIV_FAST_MULT_EN
            if (fast_op) begin
                acc_q <= fast_prod;
                neg_q <= 1'b0;
            end
`endif
        end else if (state == ST_CALC) begin
            acc_q <= step_acc;
        end
    end

    // Sign correction and divide-by-zero override, consumed in FIX.
    always_comb begin
        res_hi = acc_q[63:32];
        res_lo = acc_q[31:0];
        if (op_q_div) begin
            if (div_zero_q) begin
                res_hi = data1_q;
                res_lo = '1;
            end else begin
                res_lo = neg_q ? -acc_q[31:0]  : acc_q[31:0];
                res_hi = neg_r ? -acc_q[63:32] : acc_q[63:32];
            end
        end else if (neg_q) begin
            {res_hi, res_lo} = -acc_q;
        end
    end

    // HI/LO: result lands at the end of FIX unless flushed; MTHI/MTLO only
    // when idle, so a write coincident with an accepted start still lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (state == ST_FIX) begin
            if (!flush) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end else if (!busy) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data1, data2;
    logic        flush;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .data1 (data1),
        .data2 (data2),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;
    int   n_vec    = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sbv, q, r;
        logic [63:0] ua, ub, uq, ur, p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        p   = '0;
        case (o)
            2'b00: p = sa * sbv;
            2'b01: p = ua * ub;
            default: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else if (o == 2'b10) begin
                    q = sa / sbv;
                    r = sa % sbv;
                    p = {r[31:0], q[31:0]};
                end else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    p = {ur[31:0], uq[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    function automatic int latency(input logic [1:0] o);
`ifdef MULDIV_FAST_MULT_EN
        return o[1] ? 34 : 2;
`else
        return (o == 2'b00) ? 34 : 34;
`endif
    endfunction

    // Monitor: cycle counter plus scoreboard pop on every done pulse.
    always @(negedge clk) begin
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                got_e = sb.pop_front();
                check({got_e.tag, "_hi"}, 64'(hi), 64'(got_e.hi));
                check({got_e.tag, "_lo"}, 64'(lo), 64'(got_e.lo));
                check({got_e.tag, "_cycle"}, 64'(cyc), 64'(got_e.due));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        exp_t        e;
        logic [63:0] m;
        op    = o;
        data1 = a;
        data2 = b;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        m     = model(o, a, b);
        e.hi  = m[63:32];
        e.lo  = m[31:0];
        e.tag = tag;
        e.due = cyc + latency(o);
        sb.push_back(e);
    endtask

    task automatic drain();
        int budget = 0;
        while (sb.size() != 0 && budget < 100) begin
            tick(1);
            budget++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        int dn0;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        rst_n = 1'b0; start = 1'b0; op = 2'b00; data1 = '0; data2 = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        tick(3);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        rst_n = 1'b1;
        tick(1);

        // MTHI / MTLO while idle
        hi_we = 1'b1; wdata = 32'hA5A5_0001; tick(1); hi_we = 1'b0;
        lo_we = 1'b1; wdata = 32'h5A5A_0002; tick(1); lo_we = 1'b0;
        check("mthi_idle", 64'(hi), 64'h0000_0000_A5A5_0001);
        check("mtlo_idle", 64'(lo), 64'h0000_0000_5A5A_0002);

        // Directed corner cases
        launch(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, "mult_neg");  drain();
        launch(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, "multu_big"); drain();
        launch(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg");   drain();
        launch(2'b11, 32'h0000_0007, 32'h0000_0000, "divu_zero"); drain();
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");   drain();
        launch(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, "div_negdvs"); drain();
        launch(2'b10, 32'hFFFF_FFF0, 32'h0000_0000, "div_zero");  drain();

        // Random mix, including zero and small divisors
        for (int i = 0; i < 12; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            launch(ro, ra, rb, "rand");
            drain();
        end

        // MTLO coincident with accepted start: write lands, result overwrites
        lo_we = 1'b1; wdata = 32'h0000_CAFE;
        launch(2'b01, 32'd3, 32'd5, "multu_wr");
        lo_we = 1'b0;
        check("mtlo_with_start", 64'(lo), 64'h0000_0000_0000_CAFE);
        drain();

        // Flush mid-DIV after MTHI; writes and start while busy are ignored
        hi_we = 1'b1; wdata = 32'h0000_1234; tick(1); hi_we = 1'b0;
        dn0   = done_cnt;
        op = 2'b10; data1 = 32'd100; data2 = 32'd3; start = 1'b1;
        tick(1);                                   // now t+1
        start = 1'b0;
        tick(2);                                   // t+3
        hi_we = 1'b1; wdata = 32'h0000_DEAD;
        tick(1);                                   // t+4
        hi_we = 1'b0;
        check("busy_in_calc", 64'(busy), 64'd1);
        check("mthi_while_busy", 64'(hi), 64'h0000_0000_0000_1234);
        tick(1);                                   // t+5
        op = 2'b00; start = 1'b1;
        tick(1);                                   // t+6
        start = 1'b0;
        tick(4);                                   // t+10
        flush = 1'b1;
        tick(1);                                   // t+11
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hi",   64'(hi),   64'h0000_0000_0000_1234);
        check("flush_lo",   64'(lo),   64'h0000_0000_0000_000F);
        tick(40);
        check("flush_no_done", 64'(done_cnt - dn0), 64'd0);

        // Flush and start together while idle: start dropped
        dn0 = done_cnt;
        op = 2'b01; data1 = 32'd9; data2 = 32'd9; start = 1'b1; flush = 1'b1;
        tick(1);
        start = 1'b0; flush = 1'b0;
        check("flush_beats_start", 64'(busy), 64'd0);
        tick(40);
        check("flush_start_no_done", 64'(done_cnt - dn0), 64'd0);

        // Reset mid-DIV, then a normal operation
        launch(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, "div_rst");  // t+1
        tick(4);                                                  // t+5
        rst_n = 1'b0;
        tick(1);                                                  // t+6
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_hi",   64'(hi),   64'd0);
        check("rst_mid_lo",   64'(lo),   64'd0);
        sb.delete();
        rst_n = 1'b1;
        tick(1);
        launch(2'b11, 32'd1000, 32'd7, "divu_after_rst");
        drain();
        launch(2'b00, 32'h0001_0000, 32'hFFFF_0000, "mult_after_rst");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port start  input  1  launch request; sampled only when not busy.
REQ-004 SHALL have port op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; captured with start.
REQ-005 SHALL have port data1  input  32  multiplicand / dividend; captured with start.
REQ-006 SHALL have port data2  input  32  multiplier / divisor; captured with start.
REQ-007 SHALL have port flush  input  1  abort in-flight operation (pipeline exception).
REQ-008 SHALL have port hi_we  input  1  MTHI write strobe.
REQ-009 SHALL have port lo_we  input  1  MTLO write strobe.
REQ-010 SHALL have port wdata  input  32  MTHI/MTLO write data.
REQ-011 SHALL have port busy  output  1  operation in flight; pipeline stalls MFHI/MFLO/MULT/DIV on it.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port hi  output  32  HI register.
REQ-014 SHALL have port lo  output  32  LO register.

Function
REQ-015 SHALL implement FSM IDLE -> CALC -> FIX -> DONE -> IDLE; start accepted in IDLE or DONE.
REQ-016 SHALL, for start sampled at cycle t, occupy CALC t+1..t+32 (one radix-2 step per cycle), FIX at t+33, DONE at t+34.
REQ-017 SHALL assert busy in CALC and FIX only; done high only in DONE, with hi/lo already holding the result.
REQ-018 SHALL compute signed ops on magnitudes, then apply sign correction in FIX: product sign = sign1^sign2; quotient sign = sign1^sign2; remainder sign = sign1.
REQ-019 SHALL write 64-bit product as {hi,lo}; division writes lo=quotient, hi=remainder.
REQ-020 SHALL, on divisor 0, write lo=0xFFFFFFFF, hi=data1 (both signedness); no exception.
REQ-021 SHALL, on DIV 0x80000000 / 0xFFFFFFFF, write lo=0x80000000, hi=0.
REQ-022 SHALL, on flush in CALC or FIX, return to IDLE next cycle with hi/lo unchanged and no done; flush in IDLE/DONE has no effect; flush with start in same cycle: flush wins, start dropped.
REQ-023 SHALL apply hi_we/lo_we only when not busy; ignored while busy.
REQ-024 SHALL, on hi_we/lo_we coincident with accepted start, perform the write; completion later overwrites it.
REQ-025 SHALL ignore start while busy (no queueing).

Reset
REQ-026 SHALL, when rst_n low at a clock edge, force state IDLE, busy=0, done=0, hi=0, lo=0, discarding any in-flight operation.
REQ-027 SHALL give reset priority over flush, start and write strobes.

Configuration
REQ-028 SHALL, with MULDIV_FAST_MULT_EN defined, compute MULT/MULTU with a single-cycle 33x33 signed multiply: CALC skipped, FIX at t+1, done at t+2.
REQ-029 SHALL, without MULDIV_FAST_MULT_EN, compute all ops iteratively per REQ-016; division always iterative.

Structure
REQ-030 SHALL place op encodings, FSM state encoding and ITER_CNT=32 in shared package muldiv_pkg.
REQ-031 SHALL instantiate sub-module muldiv_step performing one shift-add / restoring-subtract step combinationally.

Verification
REQ-032 SHALL check MULT 0xFFFFFFFF*0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, done at t+34 (t+2 with macro).
REQ-033 SHALL check MULTU 0xFFFFFFFF*0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-034 SHALL check DIV 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
REQ-035 SHALL check DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 SHALL check flush at t+10 after MTHI 0x1234 -> busy=0 at t+11, hi=0x1234, no done pulse.
REQ-037 SHALL check rst_n low at t+5 mid-DIV -> next cycle busy=0, done=0, hi=lo=0; subsequent start completes normally.
